// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2^N one-hot decoder with enable and an
// autonomous scan mode. In direct mode the output is the decoded select (A).
// In scan mode the output steps through indices from the start index up to
// LAST and wraps to 0, holding each index for DIV+1 enabled cycles. While E
// is low the output is blanked and all scan state is frozen.
module decoder_scan #(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     A,
  input  logic             E,
  input  logic             MODE,
  input  logic [DW-1:0]    DIV,
  input  logic [N-1:0]     LAST,
  output logic [2**N-1:0]  Y,
  output logic [N-1:0]     IDX,
  output logic             WRAP
);

  localparam int W = 2 ** N;

  // Operating state: last enabled edge was a direct decode, or a scan is running.
  localparam logic DIRECT = 1'b0;
  localparam logic SCAN   = 1'b1;

  logic          state_q, state_d;
  logic [N-1:0]  idx_q,   idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [W-1:0]  y_q,     y_d;
  logic          wrap_q,  wrap_d;

  logic          at_last;
  logic [N-1:0]  next_idx;
  logic [N-1:0]  start_idx;

  function automatic logic [W-1:0] onehot(input logic [N-1:0] sel);
    onehot = W'(1) << sel;
  endfunction

  // Index arithmetic: the step target, and the clamped scan start index.
  // ">=" rather than "==" so that lowering LAST below the current index
  // still wraps on the next step instead of running off the end.
  always_comb begin
    at_last   = (idx_q >= LAST);
    next_idx  = at_last ? '0 : idx_q + N'(1);
    start_idx = (A > LAST) ? '0 : A;
  end

  // Next-state decision for one enabled or disabled clock edge.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that paths
    // which do not mention it cannot infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    y_d     = '0;
    wrap_d  = 1'b0;
    if (E) begin
      if (!MODE) begin
        // Direct decode; also arms a fresh scan entry for a later MODE=1.
        state_d = DIRECT;
        idx_d   = A;
        dwell_d = '0;
        y_d     = onehot(A);
      end else if (state_q == DIRECT) begin
        // Scan entry: present the start index, never a wrap.
        state_d = SCAN;
        idx_d   = start_idx;
        dwell_d = '0;
        y_d     = onehot(start_idx);
      end else if (dwell_q < DIV) begin
        // Still dwelling: keep presenting the held index (also re-lights Y
        // after a pause).
        dwell_d = dwell_q + DW'(1);
        y_d     = onehot(idx_q);
      end else begin
        // Dwell complete: step, flagging a wrap back to index 0.
        dwell_d = '0;
        idx_d   = next_idx;
        y_d     = onehot(next_idx);
        wrap_d  = at_last;
      end
    end
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIRECT;
      idx_q   <= '0;
      dwell_q <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together
      // from values sampled at the same edge.
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y    = y_q;
  assign IDX  = idx_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: directed scenarios checked against
// constant expectation tables, plus randomized stimulus checked against a
// behavioural reference model (N=2 instance). An N=3 instance covers the
// wider decode.
module tb_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic [1:0] a;
  logic       e;
  logic       mode;
  logic [7:0] div;
  logic [1:0] last;
  logic [3:0] y;
  logic [1:0] idx;
  logic       wrap;

  logic [2:0] a3;
  logic [2:0] last3;
  logic [7:0] y3;
  logic [2:0] idx3;
  logic       wrap3;

  int vectors;
  int miscompares;

  decoder_scan #(.N(2), .DW(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .A(a), .E(e), .MODE(mode), .DIV(div),
    .LAST(last), .Y(y), .IDX(idx), .WRAP(wrap)
  );

  decoder_scan #(.N(3), .DW(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .A(a3), .E(e), .MODE(mode), .DIV(div),
    .LAST(last3), .Y(y3), .IDX(idx3), .WRAP(wrap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (N=2 instance) ----------------
  // Tracks whether a scan is running, which index is shown, and how many
  // enabled cycles that index has already been shown beyond its first.
  bit         m_scanning;
  int         m_index;
  int         m_shown;
  logic [3:0] m_y;
  logic       m_wrap;

  task automatic model_reset();
    m_scanning = 0;
    m_index    = 0;
    m_shown    = 0;
    m_y        = 4'b0000;
    m_wrap     = 1'b0;
  endtask

  task automatic model_edge();
    int lim;
    m_wrap = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (!e) begin
      m_y = 4'b0000;
    end else if (!mode) begin
      m_scanning = 0;
      m_index    = int'(a);
      m_shown    = 0;
      m_y        = 4'b0001 << m_index;
    end else if (!m_scanning) begin
      m_scanning = 1;
      m_index    = (int'(a) > int'(last)) ? 0 : int'(a);
      m_shown    = 0;
      m_y        = 4'b0001 << m_index;
    end else begin
      lim = int'(div);
      if (m_shown < lim) begin
        m_shown++;
      end else begin
        m_shown = 0;
        if (m_index >= int'(last)) begin
          m_index = 0;
          m_wrap  = 1'b1;
        end else begin
          m_index++;
        end
      end
      m_y = 4'b0001 << m_index;
    end
  endtask

  // One clock: model sees the same inputs the DUT samples, then outputs
  // settle and are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Put both DUTs into DIRECT so the next MODE=1 edge is a scan entry.
  task automatic go_direct();
    e = 1'b1; mode = 1'b0; a = 2'd0; a3 = 3'd0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    vectors++;
    if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got Y=%b IDX=%0d WRAP=%b, want Y=0000 IDX=0 WRAP=0", y, idx, wrap);
    end
    vectors++;
    if (y3 !== 8'h00 || idx3 !== 3'd0 || wrap3 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state_n3: got Y=%b IDX=%0d WRAP=%b, want zeros", y3, idx3, wrap3);
    end
  endtask

  task automatic test_direct();
    logic [3:0] exp_y [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    e = 1'b1; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i);
      tick();
      vectors++;
      if (y !== exp_y[i] || idx !== 2'(i) || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL direct[%0d]: got Y=%b IDX=%0d WRAP=%b, want Y=%b IDX=%0d WRAP=0",
                 i, y, idx, wrap, exp_y[i], i);
      end
    end
    e = 1'b0;
    tick();
    vectors++;
    if (y !== 4'b0000 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL direct_disable: got Y=%b WRAP=%b, want Y=0000 WRAP=0", y, wrap);
    end
  endtask

  task automatic test_scan_div0();
    logic [3:0] exp_y [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                              4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       exp_w [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
    go_direct();
    mode = 1'b1; div = 8'd0; last = 2'd3; a = 2'd0;
    for (int i = 0; i < 9; i++) begin
      tick();
      vectors++;
      if (y !== exp_y[i] || wrap !== exp_w[i]) begin
        miscompares++;
        $display("FAIL scan_div0[%0d]: got Y=%b WRAP=%b, want Y=%b WRAP=%b",
                 i, y, wrap, exp_y[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_scan_div2();
    logic [3:0] exp_y [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
                               4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010};
    go_direct();
    mode = 1'b1; div = 8'd2; last = 2'd2; a = 2'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (y !== exp_y[i] || wrap !== (i == 6)) begin
        miscompares++;
        $display("FAIL scan_div2[%0d]: got Y=%b WRAP=%b, want Y=%b WRAP=%b",
                 i, y, wrap, exp_y[i], (i == 6));
      end
    end
  endtask

  task automatic test_pause();
    logic [3:0] exp_y [10] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0100};
    go_direct();
    mode = 1'b1; div = 8'd3; last = 2'd3; a = 2'd1;
    for (int i = 0; i < 10; i++) begin
      e = (i >= 2 && i < 7) ? 1'b0 : 1'b1;
      tick();
      vectors++;
      if (y !== exp_y[i] || idx !== ((i < 9) ? 2'd1 : 2'd2)) begin
        miscompares++;
        $display("FAIL pause[%0d]: got Y=%b IDX=%0d, want Y=%b IDX=%0d",
                 i, y, idx, exp_y[i], (i < 9) ? 1 : 2);
      end
    end
    e = 1'b1;
  endtask

  task automatic test_last_change();
    go_direct();
    mode = 1'b1; div = 8'd0; last = 2'd3; a = 2'd3;
    tick();
    vectors++;
    if (y !== 4'b1000 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL last_change_entry: got Y=%b WRAP=%b, want Y=1000 WRAP=0", y, wrap);
    end
    last = 2'd1;
    tick();
    vectors++;
    if (y !== 4'b0001 || idx !== 2'd0 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL last_change_wrap: got Y=%b IDX=%0d WRAP=%b, want Y=0001 IDX=0 WRAP=1", y, idx, wrap);
    end
    tick();
    vectors++;
    if (y !== 4'b0010 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL last_change_step: got Y=%b WRAP=%b, want Y=0010 WRAP=0", y, wrap);
    end
    tick();
    vectors++;
    if (y !== 4'b0001 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL last_change_rewrap: got Y=%b WRAP=%b, want Y=0001 WRAP=1", y, wrap);
    end
  endtask

  task automatic test_entry_clamp();
    go_direct();
    mode = 1'b1; div = 8'd5; last = 2'd1; a = 2'd3;
    tick();
    vectors++;
    if (y !== 4'b0001 || idx !== 2'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL entry_clamp: got Y=%b IDX=%0d WRAP=%b, want Y=0001 IDX=0 WRAP=0", y, idx, wrap);
    end
  endtask

  task automatic test_last_zero();
    go_direct();
    mode = 1'b1; div = 8'd1; last = 2'd0; a = 2'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++;
      if (y !== 4'b0001 || wrap !== (i == 2 || i == 4 || i == 6)) begin
        miscompares++;
        $display("FAIL last_zero[%0d]: got Y=%b WRAP=%b, want Y=0001 WRAP=%b",
                 i, y, wrap, (i == 2 || i == 4 || i == 6));
      end
    end
  endtask

  task automatic test_n3_direct();
    e = 1'b1; mode = 1'b0; a3 = 3'd7;
    tick();
    vectors++;
    if (y3 !== 8'b1000_0000 || idx3 !== 3'd7 || wrap3 !== 1'b0) begin
      miscompares++;
      $display("FAIL n3_direct7: got Y=%b IDX=%0d WRAP=%b, want Y=10000000 IDX=7 WRAP=0", y3, idx3, wrap3);
    end
    a3 = 3'd4;
    tick();
    vectors++;
    if (y3 !== 8'b0001_0000 || idx3 !== 3'd4) begin
      miscompares++;
      $display("FAIL n3_direct4: got Y=%b IDX=%0d, want Y=00010000 IDX=4", y3, idx3);
    end
  endtask

  task automatic test_async_reset();
    go_direct();
    mode = 1'b1; div = 8'd4; last = 2'd3; a = 2'd2;
    tick();
    vectors++;
    if (y !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_setup: got Y=%b, want Y=0100", y);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got Y=%b IDX=%0d WRAP=%b, want Y=0000 IDX=0 WRAP=0", y, idx, wrap);
    end
    e = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (y !== 4'b0000 || idx !== 2'd0 || wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release[%0d]: got Y=%b IDX=%0d WRAP=%b, want zeros", i, y, idx, wrap);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      e = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 6) mode = ~mode;
      if ($urandom_range(0, 99) < 5) last = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) div = 8'($urandom_range(0, 3));
      a = 2'($urandom_range(0, 3));
      tick();
      vectors++;
      if (y !== m_y || idx !== 2'(m_index) || wrap !== m_wrap || $countones(y) > 1) begin
        miscompares++;
        $display("FAIL random[%0d]: got Y=%b IDX=%0d WRAP=%b, want Y=%b IDX=%0d WRAP=%b",
                 i, y, idx, wrap, m_y, m_index, m_wrap);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a = 2'd0; e = 1'b0; mode = 1'b0; div = 8'd0; last = 2'd0;
    a3 = 3'd0; last3 = 3'd7;
    model_reset();
    #12;
    test_reset_state();
    rst_n = 1'b1;
    test_direct();
    test_scan_div0();
    test_scan_div2();
    test_pause();
    test_last_change();
    test_entry_clamp();
    test_last_zero();
    test_n3_direct();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
